// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, access owner
// and the all-ones byte-enable pattern used for instruction fetches.
package rv32_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Wide enough for any sensible data width; users slice the low DATA_W/8 bits.
  localparam logic [127:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/rv32_mem_arbiter.sv
// Arbiter sharing one single-port unified memory between the fetch (IF) and
// load/store (LS) ports. One access is in flight at a time: grant in IDLE,
// then WAIT for the fixed memory latency and hand the read data back to the
// port that owned the access. LS has priority unless IF has been starved.
module rv32_mem_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_SAT  = STV_W'(STARVE_MAX);

  state_t            state_reg, state_next;
  owner_t            owner_reg, owner_next;
  logic [LAT_W-1:0]  lat_cnt_reg, lat_cnt_next;
  logic [STV_W-1:0]  starve_cnt_reg, starve_cnt_next;
  // Remembers that the LS access in flight is a store, so its acknowledge
  // carries zero data instead of whatever the memory returns.
  logic              store_reg, store_next;

  // IF is forced to win once LS has taken STARVE_MAX grants in a row past it.
  logic if_forced;
  assign if_forced = if_req && (starve_cnt_reg == STV_SAT);

  // Arbitration, memory drive and response routing; grants are Mealy, rvalid is Moore.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    lat_cnt_next    = lat_cnt_reg;
    starve_cnt_next = starve_cnt_reg;
    store_next      = store_reg;
    if_gnt          = 1'b0;
    ls_gnt          = 1'b0;
    if_rvalid       = 1'b0;
    ls_rvalid       = 1'b0;
    if_rdata        = '0;
    ls_rdata        = '0;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_be          = '0;
    mem_addr        = '0;
    mem_wdata       = '0;

    case (state_reg)
      IDLE: begin
        if (!rst && (if_req || ls_req)) begin
          if (ls_req && !if_forced) begin
            ls_gnt     = 1'b1;
            mem_en     = 1'b1;
            mem_we     = ls_we;
            mem_be     = ls_be;
            mem_addr   = ls_addr;
            mem_wdata  = ls_wdata;
            owner_next = OWN_LS;
            store_next = ls_we;
            // Only count grants that actually made a fetch wait.
            if (!if_req) begin
              starve_cnt_next = '0;
            end else if (starve_cnt_reg != STV_SAT) begin
              starve_cnt_next = starve_cnt_reg + 1'b1;
            end
          end else begin
            if_gnt          = 1'b1;
            mem_en          = 1'b1;
            mem_be          = BE_ALL_ONES[BE_W-1:0];
            mem_addr        = if_addr;
            owner_next      = OWN_IF;
            store_next      = 1'b0;
            starve_cnt_next = '0;
          end
          lat_cnt_next = LAT_LOAD;
          state_next   = WAIT;
        end
      end

      WAIT: begin
        if (lat_cnt_reg == '0) begin
          if (!rst) begin
            if (owner_reg == OWN_LS) begin
              ls_rvalid = 1'b1;
              ls_rdata  = store_reg ? '0 : mem_rdata;
            end else begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end
          end
          state_next = IDLE;
        end else begin
          lat_cnt_next = lat_cnt_reg - 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State, owner and counter registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_IF;
      lat_cnt_reg    <= '0;
      starve_cnt_reg <= '0;
      store_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      lat_cnt_reg    <= lat_cnt_next;
      starve_cnt_reg <= starve_cnt_next;
      store_reg      <= store_next;
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Self-checking bench for rv32_mem_arbiter. A transaction-level reference
// model (next-free cycle, pending response, starvation count) predicts every
// output each cycle; directed steps are followed by a randomized phase.
module tb_rv32_mem_arbiter;

  localparam int          MEM_LAT    = 2;
  localparam int          STARVE_MAX = 4;
  localparam logic [31:0] KEY        = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [3:0]  ls_be = '0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  rv32_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory environment: data for the address presented MEM_LAT(=2) cycles ago.
  logic [31:0] a0 = '0, a1 = '0;
  always @(posedge clk) begin
    a1 <= a0;
    a0 <= mem_addr;
  end
  assign mem_rdata = a1 ^ KEY;

  // Reference model state
  int          cyc = 0;
  int          free_cyc = 0;
  int          starve = 0;
  int          resp_cyc = 0;
  bit          resp_live = 0;
  bit          resp_ls = 0;
  bit          resp_store = 0;
  logic [31:0] resp_addr = '0;

  logic        e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv, e_en, e_we;
  logic [3:0]  e_be;
  logic [31:0] e_if_rd, e_ls_rd, e_addr, e_wdata;

  int    checks = 0;
  int    errors = 0;
  string glog = "";
  bit    logging = 0;
  int    last_if_gnt = -1;
  int    last_ls_gnt = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Expected outputs for the current cycle given the current inputs.
  task automatic model_eval();
    e_if_gnt = 0; e_ls_gnt = 0; e_if_rv = 0; e_ls_rv = 0; e_en = 0; e_we = 0;
    e_be = '0; e_if_rd = '0; e_ls_rd = '0; e_addr = '0; e_wdata = '0;
    if (!rst) begin
      if (resp_live && cyc == resp_cyc) begin
        if (resp_ls) begin
          e_ls_rv = 1;
          e_ls_rd = resp_store ? 32'h0 : (resp_addr ^ KEY);
        end else begin
          e_if_rv = 1;
          e_if_rd = resp_addr ^ KEY;
        end
      end
      if (cyc >= free_cyc) begin
        if (ls_req && !(if_req && starve == STARVE_MAX)) begin
          e_ls_gnt = 1; e_en = 1; e_we = ls_we; e_be = ls_be;
          e_addr = ls_addr; e_wdata = ls_wdata;
        end else if (if_req) begin
          e_if_gnt = 1; e_en = 1; e_be = 4'hF; e_addr = if_addr;
        end
      end
    end
  endtask

  // Advance the model across the clock edge.
  task automatic model_commit();
    if (rst) begin
      resp_live = 0;
      free_cyc  = cyc + 1;
      starve    = 0;
    end else begin
      if (resp_live && cyc == resp_cyc) resp_live = 0;
      if (e_ls_gnt || e_if_gnt) begin
        resp_live  = 1;
        resp_cyc   = cyc + MEM_LAT;
        free_cyc   = cyc + MEM_LAT + 1;
        resp_ls    = e_ls_gnt;
        resp_store = e_ls_gnt && e_we;
        resp_addr  = e_addr;
        if (e_ls_gnt) starve = if_req ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
        else          starve = 0;
        $display("cycle %0d: %s grant we=%0b be=%h addr=%h wdata=%h",
                 cyc, e_ls_gnt ? "LS" : "IF", e_we, e_be, e_addr, e_wdata);
      end
    end
    cyc++;
  endtask

  // One clock: check at negedge, advance model at posedge, retire granted requests.
  task automatic cycle();
    @(negedge clk);
    model_eval();
    chk("if_gnt",    {31'b0, if_gnt},    {31'b0, e_if_gnt});
    chk("ls_gnt",    {31'b0, ls_gnt},    {31'b0, e_ls_gnt});
    chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, e_if_rv});
    chk("ls_rvalid", {31'b0, ls_rvalid}, {31'b0, e_ls_rv});
    chk("if_rdata",  if_rdata,           e_if_rd);
    chk("ls_rdata",  ls_rdata,           e_ls_rd);
    chk("mem_en",    {31'b0, mem_en},    {31'b0, e_en});
    chk("mem_we",    {31'b0, mem_we},    {31'b0, e_we});
    chk("mem_be",    {28'b0, mem_be},    {28'b0, e_be});
    chk("mem_addr",  mem_addr,           e_addr);
    chk("mem_wdata", mem_wdata,          e_wdata);
    if (logging) begin
      if (ls_gnt) glog = {glog, "L"};
      if (if_gnt) glog = {glog, "I"};
    end
    if (ls_gnt) last_ls_gnt = cyc;
    if (if_gnt) last_if_gnt = cyc;
    @(posedge clk);
    model_commit();
    #1;
    if (e_if_gnt) if_req = 0;
    if (e_ls_gnt) ls_req = 0;
  endtask

  initial begin
    #1;
    // 1. Reset with both requests up: nothing may leak out.
    rst = 1; if_req = 1; if_addr = 32'h0000_0008;
    ls_req = 1; ls_addr = 32'h0000_00F0;
    repeat (3) cycle();
    ls_req = 0; rst = 0;
    repeat (3) cycle();

    // 2. Single fetch.
    if_req = 1; if_addr = 32'h0000_0010;
    repeat (3) cycle();

    // 3. Store with partial byte enables.
    ls_req = 1; ls_we = 1; ls_be = 4'b0011; ls_addr = 32'h40; ls_wdata = 32'h1234_5678;
    repeat (3) cycle();
    ls_we = 0; ls_be = 4'hF;

    // 4. Simultaneous requests: LS first, IF three cycles later.
    if_req = 1; if_addr = 32'h4; ls_req = 1; ls_addr = 32'h80; ls_wdata = 32'h0;
    repeat (6) cycle();
    chk("if_after_ls_gap", 32'(last_if_gnt - last_ls_gnt), 32'd3);

    // 5. Starvation: LS keeps requesting, IF waits for its forced turn.
    logging = 1; glog = "";
    if_req = 1; if_addr = 32'h100;
    for (int n = 0; n < 60 && glog.len() < 6; n++) begin
      if (!ls_req) begin
        ls_req = 1; ls_we = 1'($urandom()); ls_be = 4'($urandom());
        ls_addr = 32'h200 + 32'(n * 4); ls_wdata = $urandom();
      end
      cycle();
    end
    logging = 0; ls_req = 0; if_req = 0;
    checks++;
    assert (glog == "LLLLIL")
    else begin
      errors++;
      $error("FAIL starve_order observed=%s expected=LLLLIL", glog);
    end
    repeat (3) cycle();

    // 6. Reset one cycle after an LS grant abandons the access.
    ls_req = 1; ls_we = 0; ls_addr = 32'h300;
    cycle();
    rst = 1; cycle();
    rst = 0; repeat (2) cycle();
    if_req = 1; if_addr = 32'h20;
    repeat (3) cycle();

    // 7. Randomized traffic with occasional withdrawals and resets.
    for (int n = 0; n < 500; n++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!ls_req && $urandom_range(0, 2) == 0) begin
        ls_req = 1; ls_we = 1'($urandom()); ls_be = 4'($urandom());
        ls_addr = $urandom() & 32'hFFFF_FFFC; ls_wdata = $urandom();
      end else if (ls_req && $urandom_range(0, 15) == 0) begin
        ls_req = 0;
      end
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 0; if_req = 0; ls_req = 0;
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
